io_bus_master: RTL and testbench



---
 rtl/io_bus_master.sv | 209 ++++++++++++++++++++
 tb/tb_io_bus_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_master.sv
// Valid/ready command initiator for the 8-bit memory-mapped IO bus (write/read bursts, poll).
// Define IO_BUS_MASTER_POLL_EN to support the poll op; otherwise op 10 is rejected like op 11.
module io_bus_master #(
    parameter int unsigned POLL_LIMIT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_op,
    input  logic [7:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    input  logic [7:0] i_cmd_mask,
    input  logic [7:0] i_cmd_count,
    input  logic       i_cmd_inc,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_last,
    output logic       o_rsp_err,
    output logic [7:0] o_io_address,
    output logic [7:0] o_io_dout,
    output logic       o_io_w_en,
    output logic       o_io_r_en,
    input  logic [7:0] i_io_din
);

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned CW  = 8;
    localparam int unsigned PCW = 16;
    localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);
    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
`ifdef IO_BUS_MASTER_POLL_EN
    localparam logic [1:0] OP_POLL = 2'b10;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_CAP,
        S_RSP
`ifdef IO_BUS_MASTER_POLL_EN
        , S_POLL_REQ
        , S_POLL_CAP
`endif
    } state_t;

    state_t          r_state;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_last;
    logic            r_rsp_err;
    logic [AW-1:0]   r_io_address;
    logic [DW-1:0]   r_io_dout;
    logic            r_io_w_en;
    logic            r_io_r_en;
    logic [CW-1:0]   r_beats;
    logic            r_inc;
`ifdef IO_BUS_MASTER_POLL_EN
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   r_mask;
    logic [PCW-1:0]  r_attempts;
`endif
    logic            w_unused_ok;

    assign w_unused_ok = ^{i_cmd_mask, POLL_MAX};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_last   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_io_address <= '0;
            r_io_dout    <= '0;
            r_io_w_en    <= 1'b0;
            r_io_r_en    <= 1'b0;
            r_beats      <= '0;
            r_inc        <= 1'b0;
`ifdef IO_BUS_MASTER_POLL_EN
            r_data       <= '0;
            r_mask       <= '0;
            r_attempts   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (i_cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_beats     <= i_cmd_count;
                        r_inc       <= i_cmd_inc;
                        case (i_cmd_op)
                            OP_WR: begin
                                r_io_w_en    <= 1'b1;
                                r_io_address <= i_cmd_addr;
                                r_io_dout    <= i_cmd_data;
                                r_state      <= S_WRITE;
                            end
                            OP_RD: begin
                                r_io_r_en    <= 1'b1;
                                r_io_address <= i_cmd_addr;
                                r_state      <= S_RD_REQ;
                            end
`ifdef IO_BUS_MASTER_POLL_EN
                            OP_POLL: begin
                                r_io_r_en    <= 1'b1;
                                r_io_address <= i_cmd_addr;
                                r_data       <= i_cmd_data;
                                r_mask       <= i_cmd_mask;
                                r_attempts   <= PCW'(1);
                                r_beats      <= '0;
                                r_state      <= S_POLL_REQ;
                            end
`endif
                            default: begin
                                // Rejected op: answer at once without touching the bus
                                r_beats     <= '0;
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= '0;
                                r_rsp_err   <= 1'b1;
                                r_rsp_last  <= 1'b1;
                                r_state     <= S_RSP;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (r_beats == '0) begin
                        r_io_w_en   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_beats      <= r_beats - CW'(1);
                        r_io_address <= r_io_address + AW'(r_inc);
                    end
                end
                S_RD_REQ: begin
                    r_io_r_en <= 1'b0;
                    r_state   <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= i_io_din;
                    r_rsp_last  <= (r_beats == '0);
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_beats != '0) begin
                            r_beats      <= r_beats - CW'(1);
                            r_io_address <= r_io_address + AW'(r_inc);
                            r_io_r_en    <= 1'b1;
                            r_state      <= S_RD_REQ;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
`ifdef IO_BUS_MASTER_POLL_EN
                S_POLL_REQ: begin
                    r_io_r_en <= 1'b0;
                    r_state   <= S_POLL_CAP;
                end
                S_POLL_CAP: begin
                    if ((i_io_din & r_mask) == (r_data & r_mask)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= i_io_din;
                        r_rsp_err   <= 1'b0;
                        r_rsp_last  <= 1'b1;
                        r_state     <= S_RSP;
                    end else if (r_attempts < POLL_MAX) begin
                        r_attempts <= r_attempts + PCW'(1);
                        r_io_r_en  <= 1'b1;
                        r_state    <= S_POLL_REQ;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= i_io_din;
                        r_rsp_err   <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_last   = r_rsp_last;
    assign o_rsp_err    = r_rsp_err;
    assign o_io_address = r_io_address;
    assign o_io_dout    = r_io_dout;
    assign o_io_w_en    = r_io_w_en;
    assign o_io_r_en    = r_io_r_en;

endmodule

// File: tb/tb_io_bus_master.sv
// Randomized self-checking bench for io_bus_master against a transaction-level reference model.
module tb_io_bus_master;

    localparam int         TB_POLL_LIMIT = 10;
    localparam logic [7:0] POLL_ADDR     = 8'hA0;
    localparam int         BUDGET        = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready;
    logic [1:0] i_cmd_op = '0;
    logic [7:0] i_cmd_addr = '0;
    logic [7:0] i_cmd_data = '0;
    logic [7:0] i_cmd_mask = '0;
    logic [7:0] i_cmd_count = '0;
    logic       i_cmd_inc = 1'b0;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b0;
    logic [7:0] o_rsp_data;
    logic       o_rsp_last;
    logic       o_rsp_err;
    logic [7:0] o_io_address;
    logic [7:0] o_io_dout;
    logic       o_io_w_en;
    logic       o_io_r_en;
    logic [7:0] i_io_din = '0;

    io_bus_master #(.POLL_LIMIT(TB_POLL_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_mask(i_cmd_mask),
        .i_cmd_count(i_cmd_count), .i_cmd_inc(i_cmd_inc),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
        .o_rsp_last(o_rsp_last), .o_rsp_err(o_rsp_err),
        .o_io_address(o_io_address), .o_io_dout(o_io_dout),
        .o_io_w_en(o_io_w_en), .o_io_r_en(o_io_r_en), .i_io_din(i_io_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Peripheral: RAM everywhere except a status pin at POLL_ADDR whose bit0 rises after flip_at reads
    logic [7:0] mem [256];
    int pin_reads = 0;
    int flip_at = 0;
    always @(posedge clk) begin
        if (o_io_w_en) mem[o_io_address] <= o_io_dout;
        if (o_io_r_en) begin
            if (o_io_address == POLL_ADDR) begin
                i_io_din  <= 8'h54 | 8'(pin_reads >= flip_at);
                pin_reads <= pin_reads + 1;
            end else begin
                i_io_din <= mem[o_io_address];
            end
        end
    end

    // Bus/response monitor, sampled on the falling edge
    logic [15:0] obs_wr[$];
    int          obs_wr_cyc[$];
    logic [7:0]  obs_rd[$];
    int          obs_rd_cyc[$];
    logic [9:0]  obs_rsp[$];
    int          obs_hs_cyc[$];
    int          v_first = -1;
    int          overlap = 0;
    int          stab_err = 0;
    logic [9:0]  held = '0;
    bit          held_v = 1'b0;

    always @(negedge clk) begin
        if (o_io_w_en) begin
            obs_wr.push_back({o_io_address, o_io_dout});
            obs_wr_cyc.push_back(cyc);
        end
        if (o_io_r_en) begin
            obs_rd.push_back(o_io_address);
            obs_rd_cyc.push_back(cyc);
        end
        if (o_io_w_en && o_io_r_en) overlap++;
        if (o_rsp_valid && v_first < 0) v_first = cyc;
        if (held_v && o_rsp_valid && ({o_rsp_data, o_rsp_last, o_rsp_err} != held)) stab_err++;
        held   = {o_rsp_data, o_rsp_last, o_rsp_err};
        held_v = o_rsp_valid && !i_rsp_ready;
        if (o_rsp_valid && i_rsp_ready) begin
            obs_rsp.push_back({o_rsp_data, o_rsp_last, o_rsp_err});
            obs_hs_cyc.push_back(cyc);
        end
    end

    // Reference model: expected bus traffic, responses and duration of one command
    logic [7:0]  shadow [256];
    int          model_preads = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [9:0]  exp_rsp[$];
    int          exp_dur;

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [7:0] v;
        if (a == POLL_ADDR) begin
            v = 8'h54 | 8'(model_preads >= flip_at);
            model_preads++;
        end else begin
            v = shadow[a];
        end
        return v;
    endfunction

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                             input logic [7:0] mask, input logic [7:0] count, input logic inc);
        logic [7:0] a;
        logic [7:0] s;
        bit         hit;
        a = addr;
        exp_wr.delete();
        exp_rd.delete();
        exp_rsp.delete();
        if (op == 2'b00) begin
            for (int i = 0; i <= int'(count); i++) begin
                exp_wr.push_back({a, data});
                shadow[a] = data;
                a = a + 8'(inc);
            end
            exp_dur = int'(count) + 1;
        end else if (op == 2'b01) begin
            for (int i = 0; i <= int'(count); i++) begin
                exp_rd.push_back(a);
                exp_rsp.push_back({model_read(a), (i == int'(count)), 1'b0});
                a = a + 8'(inc);
            end
            exp_dur = 3 * (int'(count) + 1);
`ifdef IO_BUS_MASTER_POLL_EN
        end else if (op == 2'b10) begin
            hit = 1'b0;
            s = '0;
            for (int k = 0; k < TB_POLL_LIMIT && !hit; k++) begin
                exp_rd.push_back(addr);
                s = model_read(addr);
                hit = ((s & mask) == (data & mask));
            end
            exp_rsp.push_back({s, 1'b1, !hit});
            exp_dur = 2 * exp_rd.size() + 1;
`endif
        end else begin
            exp_rsp.push_back({8'h00, 1'b1, 1'b1});
            exp_dur = 1;
        end
    endtask

    task automatic clear_obs();
        obs_wr.delete();
        obs_wr_cyc.delete();
        obs_rd.delete();
        obs_rd_cyc.delete();
        obs_rsp.delete();
        obs_hs_cyc.delete();
        v_first = -1;
    endtask

    // Issue one command, run it to completion, then compare against the model
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [7:0] addr,
                          input logic [7:0] data, input logic [7:0] mask, input logic [7:0] count,
                          input logic inc, input int bp, output int acc);
        int done;
        int vcnt;
        int w;
        done = -1;
        vcnt = 0;
        w = 0;
        clear_obs();
        while (!o_cmd_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        i_cmd_op = op; i_cmd_addr = addr; i_cmd_data = data; i_cmd_mask = mask;
        i_cmd_count = count; i_cmd_inc = inc; i_cmd_valid = 1'b1; i_rsp_ready = 1'b0;
        @(posedge clk); #1;
        acc = cyc;
        i_cmd_valid = 1'b0;
        for (int c = 0; c < BUDGET && done < 0; c++) begin
            if (o_cmd_ready) begin
                done = cyc;
            end else begin
                if (o_rsp_valid) vcnt++;
                case (bp)
                    0:       i_rsp_ready = 1'b1;
                    1:       i_rsp_ready = 1'($urandom_range(0, 1));
                    default: i_rsp_ready = (vcnt > 5);
                endcase
                @(posedge clk); #1;
            end
        end
        model_cmd(op, addr, data, mask, count, inc);
        check($sformatf("%s_completes", tag), done >= 0, 1);
        if (bp == 0) check($sformatf("%s_cycles", tag), done - acc, exp_dur);
        check($sformatf("%s_n_wr", tag), obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), obs_wr[i], exp_wr[i]);
        check($sformatf("%s_n_rd", tag), obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), obs_rd[i], exp_rd[i]);
        check($sformatf("%s_n_rsp", tag), obs_rsp.size(), exp_rsp.size());
        for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++)
            check($sformatf("%s_rsp%0d", tag, i), obs_rsp[i], exp_rsp[i]);
    endtask

    initial begin
        int acc;
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] mask;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end

        #3;
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_strobes", {o_io_w_en, o_io_r_en}, 0);
        check("rst_bus", {o_io_address, o_io_dout, o_rsp_data, o_rsp_last, o_rsp_err}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready_held_low", o_cmd_ready, 0);
        @(posedge clk); #1;
        check("rst_ready_after", o_cmd_ready, 1);

        do_cmd("wr_burst", 2'b00, 8'hFE, 8'h5A, 8'h00, 8'd2, 1'b1, 0, acc);
        check("wr_burst_first_cyc", at(obs_wr_cyc, 0), acc);
        check("wr_burst_last_cyc", at(obs_wr_cyc, 2), acc + 2);

        do_cmd("wr_seed", 2'b00, 8'h02, 8'h3C, 8'h00, 8'd0, 1'b0, 0, acc);
        do_cmd("rd_single", 2'b01, 8'h02, 8'h00, 8'h00, 8'd0, 1'b0, 0, acc);
        check("rd_single_ren_cyc", at(obs_rd_cyc, 0), acc);
        check("rd_single_valid_cyc", v_first, acc + 2);

        do_cmd("rd_bp", 2'b01, 8'h02, 8'h00, 8'h00, 8'd1, 1'b0, 2, acc);
        check("rd_bp_hold", at(obs_hs_cyc, 0) - v_first, 5);
        check("rd_bp_second_ren", at(obs_rd_cyc, 1), at(obs_hs_cyc, 0) + 1);

`ifdef IO_BUS_MASTER_POLL_EN
        flip_at = model_preads + 7;
        do_cmd("poll_ok", 2'b10, POLL_ADDR, 8'h01, 8'h01, 8'd0, 1'b0, 0, acc);
        check("poll_ok_reads", obs_rd.size(), 8);
        check("poll_ok_spacing", at(obs_rd_cyc, 1) - at(obs_rd_cyc, 0), 2);
        flip_at = 32'h4000_0000;
        do_cmd("poll_to", 2'b10, POLL_ADDR, 8'h01, 8'h01, 8'd0, 1'b0, 0, acc);
        check("poll_to_reads", obs_rd.size(), TB_POLL_LIMIT);
`else
        do_cmd("op10_off", 2'b10, POLL_ADDR, 8'h01, 8'h01, 8'd0, 1'b0, 0, acc);
`endif
        do_cmd("op11", 2'b11, 8'h33, 8'h44, 8'hFF, 8'd5, 1'b1, 0, acc);

        clear_obs();
        i_cmd_op = 2'b00; i_cmd_addr = 8'h40; i_cmd_data = 8'h77; i_cmd_count = 8'd3;
        i_cmd_inc = 1'b1; i_cmd_valid = 1'b1;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_wen_pre", o_io_w_en, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_wen_drop", o_io_w_en, 0);
        check("rst_mid_ready_low", o_cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ready_after", o_cmd_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_n_wr", obs_wr.size(), 2);
        check("rst_mid_n_rd", obs_rd.size(), 0);
        check("rst_mid_n_rsp", obs_rsp.size(), 0);
        shadow[8'h40] = 8'h77;
        do_cmd("rst_mid_readback", 2'b01, 8'h40, 8'h00, 8'h00, 8'd1, 1'b1, 0, acc);

        do_cmd("wr_256", 2'b00, 8'h80, 8'($urandom), 8'h00, 8'd255, 1'b1, 0, acc);
        do_cmd("rd_wrap", 2'b01, 8'hFE, 8'h00, 8'h00, 8'd3, 1'b1, 1, acc);

        for (int n = 0; n < 40; n++) begin
            op   = 2'($urandom_range(0, 3));
            addr = 8'($urandom);
            data = 8'($urandom);
            mask = 8'($urandom);
            if (op == 2'b10) begin
                addr = POLL_ADDR;
                mask = mask | 8'h01;
                flip_at = model_preads + int'($urandom_range(0, 12));
            end
            do_cmd($sformatf("rnd%0d", n), op, addr, data, mask, 8'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), acc);
        end

        check("strobe_overlap", overlap, 0);
        check("rsp_stable", stab_err, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
